// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel scan multiplexer: mode encodings and
// the select-width helper used to size channel indices.
package chan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A single channel still needs a one-bit index, hence the floor of 1.
    function automatic int selw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running scan prescaler: counts enabled cycles 0..SCAN_DIV-1 and flags
// the terminal count combinationally so the parent can step on that same edge.
module scan_prescaler #(
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (SCAN_DIV <= 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST_CNT);

    // clr wins over en; with neither, the count is frozen in place.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-channel selector with out-of-range select protection,
// timed auto-scan across channels and a hold control that freezes the display.
module chan_scan_mux
    import chan_mux_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 3,
    parameter  int SCAN_DIV = 50_000_000,
    localparam int SELW     = selw_f(CHANNELS)
) (
    input  logic                      CLOCK_50,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SELW-1:0]           cur_chan,
    output logic                      sel_err,
    output logic                      tick
);

    localparam logic [SELW-1:0] LAST_CHAN = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   CHAN_LIM  = (SELW + 1)'(CHANNELS);

    logic             presc_en;
    logic             presc_clr;
    logic             step;
    logic [SELW-1:0]  next_chan;
    logic             sel_err_nxt;
    logic [WIDTH-1:0] chan_data [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_slice
        assign chan_data[c] = data_in[c*WIDTH +: WIDTH];
    end

    assign presc_en  = (mode == MODE_SCAN) && !hold;
    assign presc_clr = (mode == MODE_MANUAL);

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .en       (presc_en),
        .clr      (presc_clr),
        .tick     (step)
    );

    // Wrap compares against the last channel explicitly so non-power-of-two
    // channel counts never index past the final slice.
    always_comb begin
        next_chan   = cur_chan;
        sel_err_nxt = sel_err;
        if (!hold) begin
            if (mode == MODE_SCAN) begin
                sel_err_nxt = 1'b0;
                if (step) begin
                    next_chan = (cur_chan == LAST_CHAN) ? '0 : cur_chan + 1'b1;
                end
            end else if ({1'b0, sel} < CHAN_LIM) begin
                next_chan   = sel;
                sel_err_nxt = 1'b0;
            end else begin
                sel_err_nxt = 1'b1;
            end
        end
    end

    // data_out and cur_chan always load from the same next_chan so they agree.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            data_out <= '0;
            cur_chan <= '0;
            sel_err  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= step;
            if (!hold) begin
                cur_chan <= next_chan;
                data_out <= chan_data[next_chan];
                sel_err  <= sel_err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: expectations queued as stimulus is applied,
// then popped and compared against the registered outputs after each edge.
module tb_chan_scan_mux;

    localparam int WIDTH    = 2;
    localparam int CHANNELS = 3;
    localparam int SCAN_DIV = 4;
    localparam logic [5:0] BASE = 6'b10_01_11;

    logic       CLOCK_50 = 1'b0;
    logic       Reset    = 1'b0;
    logic [5:0] data_in;
    logic [1:0] sel;
    logic       mode;
    logic       hold;
    logic [1:0] data_out;
    logic [1:0] cur_chan;
    logic       sel_err;
    logic       tick;

    typedef struct {
        string      tag;
        logic [1:0] data;
        logic [1:0] chan;
        logic       err;
        logic       tck;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] chv [3];
    int         mchan;
    logic       mtick;

    chan_scan_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .data_in  (data_in),
        .sel      (sel),
        .mode     (mode),
        .hold     (hold),
        .data_out (data_out),
        .cur_chan (cur_chan),
        .sel_err  (sel_err),
        .tick     (tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [1:0] d, input logic [1:0] c,
                        input logic e, input logic t);
        exp_t x;
        x.tag  = tag;
        x.data = d;
        x.chan = c;
        x.err  = e;
        x.tck  = t;
        sb.push_back(x);
    endtask

    task automatic check_next();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: got nothing queued, required one expectation");
            return;
        end
        x = sb.pop_front();
        assert ({data_out, cur_chan, sel_err, tick} === {x.data, x.chan, x.err, x.tck})
        else begin
            failures++;
            $error("FAIL %s: got data=%b chan=%0d err=%b tick=%b, required data=%b chan=%0d err=%b tick=%b",
                   x.tag, data_out, cur_chan, sel_err, tick, x.data, x.chan, x.err, x.tck);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] d, input logic [1:0] c,
                        input logic e, input logic t);
        push(tag, d, c, e, t);
        cycle();
        check_next();
    endtask

    initial begin
        chv[0] = 2'b11;
        chv[1] = 2'b01;
        chv[2] = 2'b10;
        data_in = BASE;
        sel     = 2'd0;
        mode    = 1'b0;
        hold    = 1'b0;

        // Asynchronous reset assertion before any clock edge.
        #2 Reset = 1'b1;
        #1;
        push("reset_async", 2'b00, 2'd0, 1'b0, 1'b0);
        check_next();
        sel = 2'd3;
        step("reset_held", 2'b00, 2'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Manual selection and out-of-range protection.
        sel = 2'd1;
        step("manual_sel1", chv[1], 2'd1, 1'b0, 1'b0);
        sel = 2'd2;
        step("manual_sel2", chv[2], 2'd2, 1'b0, 1'b0);
        sel = 2'd3;
        step("oor_keep", chv[2], 2'd2, 1'b1, 1'b0);
        data_in = 6'b01_01_11;
        step("oor_refresh", 2'b01, 2'd2, 1'b1, 1'b0);
        data_in = BASE;
        step("oor_restore", chv[2], 2'd2, 1'b1, 1'b0);
        sel = 2'd0;
        step("oor_recover", chv[0], 2'd0, 1'b0, 1'b0);
        sel = 2'd1;
        step("manual_back1", chv[1], 2'd1, 1'b0, 1'b0);

        // Auto-scan from channel 1 with sel out of range (ignored).
        mode  = 1'b1;
        sel   = 2'd3;
        mchan = 1;
        for (int k = 1; k <= 12; k++) begin
            mtick = (k % SCAN_DIV == 0);
            if (mtick) mchan = (mchan == CHANNELS - 1) ? 0 : mchan + 1;
            step($sformatf("scan_k%0d", k), chv[mchan], 2'(mchan), 1'b0, mtick);
        end

        // Advance prescaler to 2, then hold for 10 cycles while ch1 data changes.
        step("prehold_1", chv[1], 2'd1, 1'b0, 1'b0);
        step("prehold_2", chv[1], 2'd1, 1'b0, 1'b0);
        hold    = 1'b1;
        data_in = 6'b10_00_11;
        for (int k = 1; k <= 10; k++) begin
            step($sformatf("hold_k%0d", k), chv[1], 2'd1, 1'b0, 1'b0);
        end
        hold    = 1'b0;
        data_in = BASE;
        step("release_1", chv[1], 2'd1, 1'b0, 1'b0);
        step("release_2", chv[2], 2'd2, 1'b0, 1'b1);

        // Bring prescaler to 3, then reset between edges.
        step("prerst_1", chv[2], 2'd2, 1'b0, 1'b0);
        step("prerst_2", chv[2], 2'd2, 1'b0, 1'b0);
        step("prerst_3", chv[2], 2'd2, 1'b0, 1'b0);
        #2 Reset = 1'b1;
        #1;
        push("rst_midscan", 2'b00, 2'd0, 1'b0, 1'b0);
        check_next();
        step("rst_edge", 2'b00, 2'd0, 1'b0, 1'b0);
        Reset = 1'b0;
        step("postrst_1", chv[0], 2'd0, 1'b0, 1'b0);
        step("postrst_2", chv[0], 2'd0, 1'b0, 1'b0);
        step("postrst_3", chv[0], 2'd0, 1'b0, 1'b0);
        step("postrst_4", chv[1], 2'd1, 1'b0, 1'b1);

        // Switch to manual on the terminal-count edge.
        step("premode_1", chv[1], 2'd1, 1'b0, 1'b0);
        step("premode_2", chv[1], 2'd1, 1'b0, 1'b0);
        step("premode_3", chv[1], 2'd1, 1'b0, 1'b0);
        mode = 1'b0;
        sel  = 2'd2;
        step("mode_switch", chv[2], 2'd2, 1'b0, 1'b0);

        // Re-enter scan: prescaler restarted, scanning continues from channel 2.
        mode = 1'b1;
        step("rescan_1", chv[2], 2'd2, 1'b0, 1'b0);
        step("rescan_2", chv[2], 2'd2, 1'b0, 1'b0);
        step("rescan_3", chv[2], 2'd2, 1'b0, 1'b0);
        step("rescan_4", chv[0], 2'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
